// File: rtl/multi_cycle_core.sv
// Multi-cycle 16-bit ISA core: FETCH/DECODE/EXEC/MEM/WB FSM over one shared req/ack memory port.
// Optional: define TRAP_ILLEGAL_EN to park in TRAP on ops 101/110 instead of treating them as NOPs.
module multi_cycle_core #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned PC_INC   = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [2:0]        state_out,
  output logic              halted
);

  localparam int unsigned IR_W  = 16;
  localparam int unsigned IMM_W = 7;
  localparam int unsigned REG_N = 8;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;
  localparam logic [3:0] FN_SLT = 4'd4;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] pc, pc_d, pc_plus, br_off, br_target;
  logic [IR_W-1:0]   ir;
  logic [DATA_W-1:0] a, b, alu_out, mdr;
  logic [DATA_W-1:0] rf [REG_N];

  logic [2:0]        op, rs, rt, rd, dest;
  logic [3:0]        funct;
  logic [DATA_W-1:0] imm, rd_rs, rd_rt, alu_b, alu_res, wb_data;
  logic [ADDR_W-1:0] imm_a;
  logic              xfer, is_illegal, r_valid, wb_en;

  logic              mem_req_d, mem_we_d, halted_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  // Instruction field decode
  assign op     = ir[2:0];
  assign rs     = ir[5:3];
  assign rt     = ir[8:6];
  assign rd     = ir[11:9];
  assign funct  = ir[15:12];
  assign imm    = {{(DATA_W-IMM_W){ir[15]}}, ir[15:9]};
  assign imm_a  = {{(ADDR_W-IMM_W){ir[15]}}, ir[15:9]};

  assign xfer       = mem_req & mem_ack;
  assign is_illegal = (op == 3'b101) || (op == 3'b110);
  assign r_valid    = (funct <= FN_SLT);

  assign rd_rs = (rs == 3'd0) ? '0 : rf[rs];
  assign rd_rt = (rt == 3'd0) ? '0 : rf[rt];

  // PC already points past the branch when EXEC runs, so the offset is added to it directly
  assign pc_plus   = pc + ADDR_W'(PC_INC);
  assign br_off    = imm_a * ADDR_W'(PC_INC);
  assign br_target = pc + br_off;

  assign dest    = (op == OP_R) ? rd : rt;
  assign wb_data = (op == OP_LW) ? mdr : alu_out;
  assign wb_en   = (dest != 3'd0) &&
                   (((op == OP_R) && r_valid) || (op == OP_ADDI) || (op == OP_LW));

  assign state_out = state;

  // Shared ALU: R-type ops, address/addi add, beq compare via subtract
  always_comb begin
    alu_b   = imm;
    alu_res = '0;
    if (op == OP_R || op == OP_BEQ) alu_b = b;
    if (op == OP_R) begin
      case (funct)
        FN_ADD:  alu_res = a + alu_b;
        FN_SUB:  alu_res = a - alu_b;
        FN_AND:  alu_res = a & alu_b;
        FN_OR:   alu_res = a | alu_b;
        FN_SLT:  alu_res = ($signed(a) < $signed(alu_b)) ? DATA_W'(1) : '0;
        default: alu_res = '0;
      endcase
    end else if (op == OP_BEQ) begin
      alu_res = a - alu_b;
    end else begin
      alu_res = a + alu_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_FETCH;
    else      state <= next_state;
  end

  // Next state plus next values of the registered memory-port outputs
  always_comb begin
    next_state  = state;
    pc_d        = pc;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;

    case (state)
      S_FETCH: begin
        if (xfer) begin
          next_state = S_DECODE;
          pc_d       = pc_plus;
        end
      end
      S_DECODE: begin
        if (op == OP_HALT) next_state = S_HALT;
`ifdef TRAP_ILLEGAL_EN
        else if (is_illegal) next_state = S_TRAP;
`endif
        else next_state = S_EXEC;
      end
      S_EXEC: begin
        if (is_illegal) begin
          next_state = S_FETCH;
        end else begin
          case (op)
            OP_R, OP_ADDI: next_state = S_WB;
            OP_LW, OP_SW:  next_state = S_MEM;
            OP_BEQ: begin
              next_state = S_FETCH;
              if (alu_res == '0) pc_d = br_target;
            end
            default:       next_state = S_FETCH;
          endcase
        end
      end
      S_MEM: begin
        if (xfer) next_state = (op == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB:    next_state = S_FETCH;
      S_HALT:  next_state = S_HALT;
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase

    mem_req_d = (next_state == S_FETCH) || (next_state == S_MEM);
    mem_we_d  = (next_state == S_MEM) && (op == OP_SW);
    halted_d  = (next_state == S_HALT) || (next_state == S_TRAP);

    // Address and store data only change when a new request starts, keeping them stable while waiting
    if (next_state == S_FETCH) begin
      mem_addr_d = pc_d;
    end else if (next_state == S_MEM && state == S_EXEC) begin
      mem_addr_d = ADDR_W'(alu_res);
      if (op == OP_SW) mem_wdata_d = b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= ADDR_W'(RESET_PC);
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= ADDR_W'(RESET_PC);
      mem_wdata <= '0;
      halted    <= 1'b0;
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    end else begin
      pc        <= pc_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      halted    <= halted_d;
      if (state == S_FETCH && xfer) ir <= mem_rdata[IR_W-1:0];
      if (state == S_DECODE) begin
        a <= rd_rs;
        b <= rd_rt;
      end
      if (state == S_EXEC) alu_out <= alu_res;
      if (state == S_MEM && xfer && op == OP_LW) mdr <= mem_rdata;
      if (state == S_WB && wb_en) rf[dest] <= wb_data;
    end
  end

endmodule

// File: tb/tb_multi_cycle_core.sv
// Directed bench for multi_cycle_core: wait-stated unified memory model, fetch log and handshake monitor.
module tb_multi_cycle_core;

  logic        clk, rst, mem_req, mem_we, mem_ack, halted;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  state_out;

  logic [15:0] mem  [64];
  logic [15:0] prog [64];
  logic        load;
  int          fetch_delay, data_delay, wait_cnt, cyc;

  logic [15:0] f_addr [64];
  int          f_cyc  [64];
  int          f_n;

  int          stab_err, wait_seen, halt_req;
  logic        pend, p_we;
  logic [15:0] p_addr, p_wd;

  int n_cmp, n_fail;

  multi_cycle_core dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .state_out(state_out), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: ack after a programmable number of wait cycles, separate delay for data accesses
  always_comb mem_ack = mem_req && (wait_cnt >= ((state_out == 3'd3) ? data_delay : fetch_delay));
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load) begin
      for (int i = 0; i < 64; i++) mem[i] <= prog[i];
      f_n <= 0;
    end else if (rst && mem_req && mem_ack && mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
    if (!rst || !mem_req || mem_ack) wait_cnt <= 0;
    else                             wait_cnt <= wait_cnt + 1;
    if (!load && rst && mem_req && mem_ack && !mem_we && state_out == 3'd0 && f_n < 64) begin
      f_addr[f_n] <= mem_addr;
      f_cyc[f_n]  <= cyc;
      f_n         <= f_n + 1;
    end
  end

  always @(negedge clk) begin
    if (load) begin
      stab_err  <= 0;
      wait_seen <= 0;
      halt_req  <= 0;
      pend      <= 1'b0;
    end else begin
      if (pend && rst && (mem_req !== 1'b1 || mem_addr !== p_addr || mem_we !== p_we ||
                          (p_we && mem_wdata !== p_wd)))
        stab_err <= stab_err + 1;
      if (rst && mem_req && !mem_ack) wait_seen <= wait_seen + 1;
      if (halted && mem_req) halt_req <= halt_req + 1;
      pend   <= rst && mem_req && !mem_ack;
      p_addr <= mem_addr;
      p_we   <= mem_we;
      p_wd   <= mem_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] r_ins(input logic [3:0] f, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {f, rd, rt, rs, 3'b000};
  endfunction

  function automatic logic [15:0] i_ins(input logic [2:0] op, input logic [2:0] rt,
                                        input logic [2:0] rs, input logic [6:0] imm);
    return {imm, rt, rs, op};
  endfunction

  task automatic clear_prog;
    for (int i = 0; i < 64; i++) prog[i] = 16'h0007;
  endtask

  task automatic start(input int fd, input int dd);
    @(negedge clk);
    rst = 1'b0; fetch_delay = fd; data_delay = dd; load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_to_halt(input string name, input int budget);
    int k = 0;
    while (halted !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_halt: got halted=%b expected 1 within %0d cycles", name, halted, budget);
    end
  endtask

  task automatic test_reset;
    clear_prog();
    @(negedge clk);
    rst = 1'b0; load = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_addr: got %h expected 0000", mem_addr); end
    n_cmp++; if (mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_wdata: got %h expected 0000", mem_wdata); end
    n_cmp++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state_out); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b expected 0", halted); end
    @(negedge clk);
    load = 1'b0;
  endtask

  // addi/addi/add then store; zero-wait latencies and halt behaviour
  task automatic test_alu_basic;
    clear_prog();
    prog[0] = i_ins(3'b001, 3'd1, 3'd0, 7'd5);
    prog[1] = i_ins(3'b001, 3'd2, 3'd0, 7'h7D);
    prog[2] = r_ins(4'd0, 3'd3, 3'd1, 3'd2);
    prog[3] = i_ins(3'b011, 3'd3, 3'd0, 7'd40);
    prog[4] = 16'h0007;
    start(0, 0);
    run_to_halt("t1", 200);
    n_cmp++; if (f_n !== 5) begin n_fail++; $display("FAIL t1_fetch_count: got %0d expected 5", f_n); end
    n_cmp++; if (f_addr[0] !== 16'd0) begin n_fail++; $display("FAIL t1_first_fetch: got %h expected 0000", f_addr[0]); end
    n_cmp++; if (f_addr[3] !== 16'd12) begin n_fail++; $display("FAIL t1_pc_after_3: got %0d expected 12", f_addr[3]); end
    n_cmp++; if (f_cyc[1] - f_cyc[0] !== 4) begin n_fail++; $display("FAIL t1_addi_lat: got %0d expected 4", f_cyc[1] - f_cyc[0]); end
    n_cmp++; if (f_cyc[3] - f_cyc[2] !== 4) begin n_fail++; $display("FAIL t1_add_lat: got %0d expected 4", f_cyc[3] - f_cyc[2]); end
    n_cmp++; if (f_cyc[4] - f_cyc[3] !== 4) begin n_fail++; $display("FAIL t1_sw_lat: got %0d expected 4", f_cyc[4] - f_cyc[3]); end
    n_cmp++; if (mem[10] !== 16'h0002) begin n_fail++; $display("FAIL t1_r3: got %h expected 0002", mem[10]); end
    repeat (8) @(negedge clk);
    n_cmp++; if (halt_req !== 0) begin n_fail++; $display("FAIL t1_halt_no_req: got %0d expected 0", halt_req); end
    n_cmp++; if (state_out !== 3'd5) begin n_fail++; $display("FAIL t1_halt_state: got %0d expected 5", state_out); end
  endtask

  // sw then lw with 3 wait cycles on each data access
  task automatic test_mem_wait;
    clear_prog();
    prog[0] = i_ins(3'b001, 3'd1, 3'd0, 7'd5);
    prog[1] = i_ins(3'b100, 3'd0, 3'd0, 7'd1);
    prog[2] = 16'h1234;
    prog[3] = i_ins(3'b011, 3'd1, 3'd0, 7'd8);
    prog[4] = i_ins(3'b010, 3'd4, 3'd0, 7'd8);
    prog[5] = i_ins(3'b011, 3'd4, 3'd0, 7'd44);
    prog[6] = 16'h0007;
    start(0, 3);
    run_to_halt("t2", 300);
    n_cmp++; if (f_addr[2] !== 16'd12) begin n_fail++; $display("FAIL t2_skip_data: got %0d expected 12", f_addr[2]); end
    n_cmp++; if (f_cyc[3] - f_cyc[2] !== 7) begin n_fail++; $display("FAIL t2_sw_lat: got %0d expected 7", f_cyc[3] - f_cyc[2]); end
    n_cmp++; if (f_cyc[4] - f_cyc[3] !== 8) begin n_fail++; $display("FAIL t2_lw_lat: got %0d expected 8", f_cyc[4] - f_cyc[3]); end
    n_cmp++; if (mem[2] !== 16'h0005) begin n_fail++; $display("FAIL t2_sw_data: got %h expected 0005", mem[2]); end
    n_cmp++; if (mem[11] !== 16'h0005) begin n_fail++; $display("FAIL t2_lw_r4: got %h expected 0005", mem[11]); end
    n_cmp++; if (stab_err !== 0) begin n_fail++; $display("FAIL t2_req_stable: got %0d changes expected 0", stab_err); end
    n_cmp++; if (wait_seen !== 9) begin n_fail++; $display("FAIL t2_wait_cycles: got %0d expected 9", wait_seen); end
  endtask

  task automatic test_branch;
    clear_prog();
    prog[0] = i_ins(3'b100, 3'd1, 3'd1, 7'd2);
    start(0, 0);
    run_to_halt("t3a", 100);
    n_cmp++; if (f_addr[1] !== 16'd12) begin n_fail++; $display("FAIL t3_taken_target: got %0d expected 12", f_addr[1]); end
    n_cmp++; if (f_cyc[1] - f_cyc[0] !== 3) begin n_fail++; $display("FAIL t3_beq_lat: got %0d expected 3", f_cyc[1] - f_cyc[0]); end

    clear_prog();
    prog[0] = i_ins(3'b001, 3'd1, 3'd0, 7'd1);
    prog[1] = i_ins(3'b100, 3'd2, 3'd1, 7'd2);
    start(0, 0);
    run_to_halt("t3b", 100);
    n_cmp++; if (f_addr[2] !== 16'd8) begin n_fail++; $display("FAIL t3_not_taken: got %0d expected 8", f_addr[2]); end

    clear_prog();
    prog[0] = i_ins(3'b100, 3'd0, 3'd0, 7'd3);
    prog[2] = 16'h0007;
    prog[4] = i_ins(3'b100, 3'd0, 3'd0, 7'h7D);
    prog[3] = i_ins(3'b001, 3'd1, 3'd0, 7'd1);
    start(0, 0);
    run_to_halt("t3c", 100);
    n_cmp++; if (f_addr[1] !== 16'd16) begin n_fail++; $display("FAIL t3_fwd_target: got %0d expected 16", f_addr[1]); end
    n_cmp++; if (f_addr[2] !== 16'd8) begin n_fail++; $display("FAIL t3_back_target: got %0d expected 8", f_addr[2]); end
  endtask

  task automatic test_rtype;
    clear_prog();
    prog[0]  = i_ins(3'b001, 3'd1, 3'd0, 7'd5);
    prog[1]  = r_ins(4'd1, 3'd5, 3'd0, 3'd1);
    prog[2]  = r_ins(4'd4, 3'd6, 3'd5, 3'd1);
    prog[3]  = r_ins(4'd0, 3'd0, 3'd1, 3'd1);
    prog[4]  = r_ins(4'd2, 3'd2, 3'd1, 3'd5);
    prog[5]  = r_ins(4'd3, 3'd3, 3'd1, 3'd5);
    prog[6]  = r_ins(4'd5, 3'd1, 3'd1, 3'd1);
    prog[7]  = i_ins(3'b011, 3'd5, 3'd0, 7'd0);
    prog[8]  = i_ins(3'b011, 3'd6, 3'd0, 7'd4);
    prog[9]  = i_ins(3'b011, 3'd0, 3'd0, 7'd8);
    prog[10] = i_ins(3'b011, 3'd2, 3'd0, 7'd12);
    prog[11] = i_ins(3'b011, 3'd3, 3'd0, 7'd16);
    prog[12] = i_ins(3'b011, 3'd1, 3'd0, 7'd20);
    prog[13] = 16'h0007;
    start(0, 0);
    run_to_halt("t4", 400);
    n_cmp++; if (mem[0] !== 16'hFFFB) begin n_fail++; $display("FAIL t4_sub: got %h expected fffb", mem[0]); end
    n_cmp++; if (mem[1] !== 16'h0001) begin n_fail++; $display("FAIL t4_slt: got %h expected 0001", mem[1]); end
    n_cmp++; if (mem[2] !== 16'h0000) begin n_fail++; $display("FAIL t4_r0: got %h expected 0000", mem[2]); end
    n_cmp++; if (mem[3] !== 16'h0001) begin n_fail++; $display("FAIL t4_and: got %h expected 0001", mem[3]); end
    n_cmp++; if (mem[4] !== 16'hFFFF) begin n_fail++; $display("FAIL t4_or: got %h expected ffff", mem[4]); end
    n_cmp++; if (mem[5] !== 16'h0005) begin n_fail++; $display("FAIL t4_funct_nop: got %h expected 0005", mem[5]); end
  endtask

  task automatic test_reset_mid;
    int k;
    int base;
    clear_prog();
    prog[0] = i_ins(3'b001, 3'd1, 3'd1, 7'd5);
    prog[1] = i_ins(3'b011, 3'd1, 3'd0, 7'd40);
    prog[10] = 16'h0000;
    start(0, 0);
    k = 0;
    while (f_n < 1 && k < 50) begin @(negedge clk); k++; end
    fetch_delay = 20;
    k = 0;
    while (!(state_out == 3'd0 && mem_req === 1'b1) && k < 50) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL t5_pending_req: got %b expected 1", mem_req); end
    n_cmp++; if (mem_addr !== 16'd4) begin n_fail++; $display("FAIL t5_pending_addr: got %0d expected 4", mem_addr); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL t5_req_after_rst: got %b expected 0", mem_req); end
    n_cmp++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL t5_state_after_rst: got %0d expected 0", state_out); end
    n_cmp++; if (mem_addr !== 16'd0) begin n_fail++; $display("FAIL t5_pc_after_rst: got %0d expected 0", mem_addr); end
    @(negedge clk);
    fetch_delay = 0;
    base = f_n;
    rst = 1'b1;
    run_to_halt("t5", 100);
    n_cmp++; if (f_addr[base] !== 16'd0) begin n_fail++; $display("FAIL t5_refetch: got %0d expected 0", f_addr[base]); end
    n_cmp++; if (mem[10] !== 16'h0005) begin n_fail++; $display("FAIL t5_r1_reset: got %h expected 0005", mem[10]); end
  endtask

  task automatic test_illegal;
    clear_prog();
    prog[0] = i_ins(3'b001, 3'd1, 3'd0, 7'd5);
    prog[1] = 16'h0005;
    prog[2] = i_ins(3'b011, 3'd1, 3'd0, 7'd40);
    prog[3] = 16'h0007;
    start(0, 0);
    run_to_halt("t6", 100);
    repeat (6) @(negedge clk);
`ifdef TRAP_ILLEGAL_EN
    n_cmp++; if (state_out !== 3'd6) begin n_fail++; $display("FAIL t6_trap_state: got %0d expected 6", state_out); end
    n_cmp++; if (f_n !== 2) begin n_fail++; $display("FAIL t6_trap_fetches: got %0d expected 2", f_n); end
    n_cmp++; if (mem[10] !== 16'h0007) begin n_fail++; $display("FAIL t6_trap_no_store: got %h expected 0007", mem[10]); end
    n_cmp++; if (halt_req !== 0) begin n_fail++; $display("FAIL t6_trap_no_req: got %0d expected 0", halt_req); end
`else
    n_cmp++; if (state_out !== 3'd5) begin n_fail++; $display("FAIL t6_nop_state: got %0d expected 5", state_out); end
    n_cmp++; if (f_n !== 4) begin n_fail++; $display("FAIL t6_nop_fetches: got %0d expected 4", f_n); end
    n_cmp++; if (f_cyc[2] - f_cyc[1] !== 3) begin n_fail++; $display("FAIL t6_nop_lat: got %0d expected 3", f_cyc[2] - f_cyc[1]); end
    n_cmp++; if (mem[10] !== 16'h0005) begin n_fail++; $display("FAIL t6_nop_store: got %h expected 0005", mem[10]); end
`endif
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b0; load = 1'b0; fetch_delay = 0; data_delay = 0;
    test_reset();
    test_alu_basic();
    test_mem_wait();
    test_branch();
    test_rtype();
    test_reset_mid();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
